seg7_capture: RTL

- Receive-side counterpart of the hex-to-7-segment decoder path.
- Monitors a multiplexed 4-digit seven-segment bus (active-low cathodes CA..CG, active-low anodes AN0..AN3) and converts each stable digit pattern back to its hex nibble.
- Stores the four reconstructed digits with per-digit valid and error flags.
- Used as a loopback checker behind display drivers, and as a snooper in board-level self-test.

---
 rtl/seg7_capture.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// Seven-segment bus snooper: waits for a settled anode/cathode pattern,
// decodes it back to a hex nibble and records per-digit valid/error state.
module seg7_capture #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  ssd_seg,
    input  logic [3:0]  ssd_an,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic [3:0]  err,
    output logic        update
);

    typedef enum logic [1:0] {WAIT, CAPTURE, HOLD} state_t;

    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [6:0]       BLANK  = 7'h7F;

    state_t           state;
    logic [10:0]      s;
    logic [10:0]      s_prev;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             same;
    logic             fire;
    logic [3:0]       an_act;
    logic             one_hot;
    logic [1:0]       idx;
    logic             legal;
    logic [3:0]       nib;

    always_comb begin
        same = (s == s_prev);
        if (!same)
            cnt_next = CNT_W'(1);
        else if (cnt == SETTLE)
            cnt_next = cnt;
        else
            cnt_next = cnt + CNT_W'(1);
    end

    // Fires on the edge the count reaches SETTLE; a second fire inside one
    // stable window is only possible after a change (SETTLE_CYCLES == 1).
    always_comb begin
        fire = 1'b0;
        case (state)
            WAIT:    fire = (cnt_next == SETTLE);
            default: fire = !same && (cnt_next == SETTLE);
        endcase
    end

    always_comb begin
        an_act  = ~s[10:7];
        one_hot = 1'b1;
        idx     = 2'd0;
        case (an_act)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    always_comb begin
        legal = 1'b1;
        nib   = 4'h0;
        case (s[6:0])
            7'b0000001: nib = 4'h0;
            7'b1001111: nib = 4'h1;
            7'b0010010: nib = 4'h2;
            7'b0000110: nib = 4'h3;
            7'b1001100: nib = 4'h4;
            7'b0100100: nib = 4'h5;
            7'b0100000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0000100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b1100000: nib = 4'hB;
            7'b0110001: nib = 4'hC;
            7'b1000010: nib = 4'hD;
            7'b0110000: nib = 4'hE;
            7'b0111000: nib = 4'hF;
            default:    legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= WAIT;
            s      <= '1;
            s_prev <= '1;
            cnt    <= '0;
            digits <= '0;
            valid  <= '0;
            err    <= '0;
            update <= 1'b0;
        end else begin
            s      <= {ssd_an, ssd_seg};
            s_prev <= s;
            cnt    <= cnt_next;
            update <= 1'b0;
            if (err_clr)
                err <= '0;
            // A new error is assigned after the clear so the set wins.
            if (fire && one_hot) begin
                if (legal) begin
                    digits[{idx, 2'b00} +: 4] <= nib;
                    valid[idx]                <= 1'b1;
                    update                    <= 1'b1;
                end else if (s[6:0] == BLANK) begin
                    valid[idx] <= 1'b0;
                    update     <= 1'b1;
                end else begin
                    err[idx] <= 1'b1;
                end
            end
            case (state)
                WAIT: begin
                    if (fire)
                        state <= CAPTURE;
                end
                default: begin
                    if (fire)
                        state <= CAPTURE;
                    else if (!same)
                        state <= WAIT;
                    else
                        state <= HOLD;
                end
            endcase
        end
    end

endmodule
